// File: rtl/mux_sweep_pkg.sv
// Shared types and constants for the mux sweep sequencer.
package mux_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    localparam int unsigned DEF_N_SEL  = 3;
    localparam int unsigned DEF_SETTLE = 1;

    // Truth-table depth for a given select width.
    function automatic int unsigned tbl_w(input int unsigned n_sel);
        return 32'd1 << n_sel;
    endfunction

endpackage

// File: rtl/mux_sweep_ctrl_if.sv
// Control/result bundle between the sweep controller and its surroundings.
interface mux_sweep_ctrl_if
    import mux_sweep_pkg::*;
#(
    parameter int unsigned N_SEL = DEF_N_SEL
);
    localparam int unsigned TW = tbl_w(N_SEL);

    logic             start;
    logic [TW-1:0]    expected;
    logic             y;
    logic [N_SEL-1:0] sel;
    logic             busy;
    logic             done;
    logic [TW-1:0]    table_q;
    logic             mismatch;
    logic [N_SEL-1:0] err_idx;

    modport master (
        output start, expected, y,
        input  sel, busy, done, table_q, mismatch, err_idx
    );

    modport slave (
        input  start, expected, y,
        output sel, busy, done, table_q, mismatch, err_idx
    );
endinterface

// File: rtl/lsb_index.sv
// Lowest-set-bit encoder; found_c flags a non-zero vector.
module lsb_index #(
    parameter int unsigned W  = 8,
    parameter int unsigned IW = $clog2(W)
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx_c,
    output logic          found_c
);
    // Scan upward and keep the first hit.
    always_comb begin
        idx_c   = '0;
        found_c = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            if (vec[i] && !found_c) begin
                idx_c   = IW'(i);
                found_c = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_sweep_ctrl.sv
// Walks sel through every combination, captures y per step and compares
// the captured table against the expected table latched at start.
module mux_sweep_ctrl
    import mux_sweep_pkg::*;
#(
    parameter int unsigned N_SEL  = DEF_N_SEL,
    parameter int unsigned SETTLE = DEF_SETTLE
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_sweep_ctrl_if.slave   bus
);
    localparam int unsigned TW    = tbl_w(N_SEL);
    localparam int unsigned CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    // HOLD covers the SETTLE extra cycles; with no settle time go straight to SAMPLE.
    localparam state_t      FIRST = (SETTLE == 0) ? SAMPLE : HOLD;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [N_SEL-1:0]   sel_q;
    logic [TW-1:0]      exp_q;
    logic [TW-1:0]      tbl_q;
    logic               busy_q;
    logic               done_q;
    logic               mm_q;
    logic [N_SEL-1:0]   idx_q;

    logic               accept_c;
    logic               count_c;
    logic               capture_c;
    logic               last_c;
    logic               hold_end_c;
    logic [TW-1:0]      tbl_n_c;
    logic [TW-1:0]      diff_c;
    logic [N_SEL-1:0]   idx_c;
    logic               found_c;

    assign last_c     = (sel_q == N_SEL'(TW - 1));
    assign hold_end_c = (cnt == CNT_W'(SETTLE - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = FIRST;
            HOLD:    if (hold_end_c) state_n = SAMPLE;
            SAMPLE:  state_n = last_c ? IDLE : FIRST;
            default: state_n = IDLE;
        endcase
    end

    // Control strobes for the datapath.
    always_comb begin
        accept_c  = 1'b0;
        count_c   = 1'b0;
        capture_c = 1'b0;
        case (state)
            IDLE:    accept_c  = bus.start;
            HOLD:    count_c   = 1'b1;
            SAMPLE:  capture_c = 1'b1;
            default: ;
        endcase
    end

    // Table including the bit being sampled this cycle, so the final
    // compare sees the complete table on the last sampling edge.
    always_comb begin
        tbl_n_c        = tbl_q;
        tbl_n_c[sel_q] = bus.y;
    end

    assign diff_c = tbl_n_c ^ exp_q;

    lsb_index #(.W(TW), .IW(N_SEL)) u_lsb_index (
        .vec     (diff_c),
        .idx_c   (idx_c),
        .found_c (found_c)
    );

    // Sweep datapath: select, settle counter, captured table and results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            sel_q  <= '0;
            exp_q  <= '0;
            tbl_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            mm_q   <= 1'b0;
            idx_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept_c) begin
                exp_q  <= bus.expected;
                tbl_q  <= '0;
                mm_q   <= 1'b0;
                idx_q  <= '0;
                sel_q  <= '0;
                cnt    <= '0;
                busy_q <= 1'b1;
            end
            if (count_c) cnt <= cnt + CNT_W'(1);
            if (capture_c) begin
                tbl_q <= tbl_n_c;
                cnt   <= '0;
                if (last_c) begin
                    sel_q  <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    mm_q   <= found_c;
                    idx_q  <= idx_c;
                end else begin
                    sel_q <= sel_q + N_SEL'(1);
                end
            end
        end
    end

    assign bus.sel      = sel_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.table_q  = tbl_q;
    assign bus.mismatch = mm_q;
    assign bus.err_idx  = idx_q;

endmodule

// File: tb/tb_mux_sweep_ctrl.sv
// Directed bench: default config driving y = A^B, plus a 2-bit,
// zero-settle instance driving y = A&B.
module tb_mux_sweep_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mux_sweep_ctrl_if #(.N_SEL(3)) bus1 ();
    mux_sweep_ctrl_if #(.N_SEL(2)) bus2 ();

    assign bus1.y = bus1.sel[2] ^ bus1.sel[1];
    assign bus2.y = bus2.sel[1] & bus2.sel[0];

    mux_sweep_ctrl #(.N_SEL(3), .SETTLE(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    mux_sweep_ctrl #(.N_SEL(2), .SETTLE(0)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] e;
        logic [7:0] tbl;
        logic       mm;
        logic [2:0] idx;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One default-config sweep; call at a negedge. keep leaves start high
    // so the next call's accept edge falls in the done cycle.
    task automatic sweep1(input vec_t v, input bit disturb, input bit keep);
        bus1.expected = v.e;
        bus1.start    = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (!keep) bus1.start = 1'b0;
            if (disturb && c == 6) begin
                bus1.start    = 1'b1;
                bus1.expected = ~v.e;
            end
            if (disturb && c == 7) bus1.start = 1'b0;
            chk("sel1", 32'(bus1.sel), 32'(c / 2));
            chk("busy1", 32'(bus1.busy), 32'd1);
            chk("done1_early", 32'(bus1.done), 32'd0);
            if (c == 0) begin
                chk("tbl1_clear", 32'(bus1.table_q), 32'd0);
                chk("mm1_clear", 32'(bus1.mismatch), 32'd0);
            end
            @(posedge clk);
        end
        @(negedge clk);
        chk("done1", 32'(bus1.done), 32'd1);
        chk("busy1_end", 32'(bus1.busy), 32'd0);
        chk("sel1_end", 32'(bus1.sel), 32'd0);
        chk("tbl1", 32'(bus1.table_q), 32'(v.tbl));
        chk("mm1", 32'(bus1.mismatch), 32'(v.mm));
        chk("idx1", 32'(bus1.err_idx), 32'(v.idx));
        if (!keep) begin
            @(negedge clk);
            chk("done1_pulse", 32'(bus1.done), 32'd0);
            chk("tbl1_hold", 32'(bus1.table_q), 32'(v.tbl));
            chk("mm1_hold", 32'(bus1.mismatch), 32'(v.mm));
        end
    endtask

    initial begin
        logic [3:0] e2 [2];
        logic [3:0] m2 [2];
        logic [1:0] i2 [2];
        bit         saw_done;

        checks = 0;
        errors = 0;
        clk    = 1'b0;
        rst_n  = 1'b0;
        bus1.start = 1'b0;  bus1.expected = '0;
        bus2.start = 1'b0;  bus2.expected = '0;

        vecs[0] = '{e: 8'b00111100, tbl: 8'b00111100, mm: 1'b0, idx: 3'd0};
        vecs[1] = '{e: 8'b00111000, tbl: 8'b00111100, mm: 1'b1, idx: 3'd2};
        vecs[2] = '{e: 8'b00111101, tbl: 8'b00111100, mm: 1'b1, idx: 3'd0};
        vecs[3] = '{e: 8'b10111100, tbl: 8'b00111100, mm: 1'b1, idx: 3'd7};
        vecs[4] = '{e: 8'b11000011, tbl: 8'b00111100, mm: 1'b1, idx: 3'd0};
        vecs[5] = '{e: 8'b00111110, tbl: 8'b00111100, mm: 1'b1, idx: 3'd1};

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_sel", 32'(bus1.sel), 32'd0);
        chk("rst_busy", 32'(bus1.busy), 32'd0);
        chk("rst_done", 32'(bus1.done), 32'd0);
        chk("rst_tbl", 32'(bus1.table_q), 32'd0);
        chk("rst_mm", 32'(bus1.mismatch), 32'd0);
        chk("rst_idx", 32'(bus1.err_idx), 32'd0);
        chk("rst_busy2", 32'(bus2.busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(bus1.busy), 32'd0);

        // Table-driven sweeps.
        for (int i = 0; i < 6; i++) sweep1(vecs[i], 1'b0, 1'b0);

        // Mid-sweep start pulse and expected change are ignored.
        sweep1(vecs[1], 1'b1, 1'b0);

        // start held high: second sweep accepted in the done cycle.
        sweep1(vecs[0], 1'b0, 1'b1);
        sweep1(vecs[3], 1'b0, 1'b0);

        // Reset at sel = 5 mid-sweep.
        bus1.expected = 8'b00111100;
        bus1.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_sel", 32'(bus1.sel), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus1.busy), 32'd0);
        chk("arst_sel", 32'(bus1.sel), 32'd0);
        chk("arst_tbl", 32'(bus1.table_q), 32'd0);
        chk("arst_mm", 32'(bus1.mismatch), 32'd0);
        chk("arst_idx", 32'(bus1.err_idx), 32'd0);
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus1.done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus1.done || bus1.busy) saw_done = 1'b1;
        end
        chk("no_done_after_rst", 32'(saw_done), 32'd0);
        sweep1(vecs[1], 1'b0, 1'b0);

        // Two-bit select, zero settle: sel changes every cycle.
        e2[0] = 4'b1000; m2[0] = 4'd0; i2[0] = 2'd0;
        e2[1] = 4'b1010; m2[1] = 4'd1; i2[1] = 2'd1;
        for (int k = 0; k < 2; k++) begin
            bus2.expected = e2[k];
            bus2.start    = 1'b1;
            @(posedge clk);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                bus2.start = 1'b0;
                chk("sel2", 32'(bus2.sel), 32'(c));
                chk("busy2", 32'(bus2.busy), 32'd1);
                chk("done2_early", 32'(bus2.done), 32'd0);
                @(posedge clk);
            end
            @(negedge clk);
            chk("done2", 32'(bus2.done), 32'd1);
            chk("busy2_end", 32'(bus2.busy), 32'd0);
            chk("tbl2", 32'(bus2.table_q), 32'(4'b1000));
            chk("mm2", 32'(bus2.mismatch), 32'(m2[k]));
            chk("idx2", 32'(bus2.err_idx), 32'(i2[k]));
            @(negedge clk);
            chk("done2_pulse", 32'(bus2.done), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
